// File: rtl/dma_writeback_engine.sv
// ---------------------------------------------------------------------------
// dma_writeback_engine
//
// Purpose:
//   Drains 32-bit words from a result FIFO, packs them pairwise (lower word
//   first) into 64-bit beats and writes each beat to system memory as a
//   single-beat transfer on the AXI-style master write channel. A job is
//   described by a destination base address and a length in bits (whole
//   32-bit words only). An odd trailing word is written as a half beat with
//   byte enables 8'h0F.
//
// Ports:
//   clk_i, rst_i            system clock, asynchronous active-high reset
//   dma_enable_i            engine enable; low aborts any job back to IDLE
//   dma_base_addr_i[31:0]   destination byte address (bits [2:0] ignored)
//   dma_bit_len_i[31:0]     job length in bits (bits [4:0] ignored)
//   dma_start_i             start request, level-sampled in IDLE
//   dma_busy_o              high while a job is active
//   dma_done_o              one-cycle pulse on successful completion
//   dma_err_o               high while in the error state
//   fifo_rd_en_o            FIFO pop strobe (data valid the following cycle)
//   fifo_rd_out_i[31:0]     FIFO read data
//   fifo_empty_i            FIFO empty flag
//   axi_waddr_o[31:0]       write address
//   axi_wdata_o[63:0]       write data
//   axi_wsel_o[7:0]         byte enables
//   axi_wvalid_o            write request valid
//   axi_wlen_o[3:0]         burst length code (4'h1 while valid)
//   axi_wfixed_o            fixed-address burst (always 0)
//   axi_werr_i              write error response
//   axi_wrdy_i              write accepted
// ---------------------------------------------------------------------------
module dma_writeback_engine #(
    parameter int unsigned WR_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dma_enable_i,
    input  logic [31:0] dma_base_addr_i,
    input  logic [31:0] dma_bit_len_i,
    input  logic        dma_start_i,
    output logic        dma_busy_o,
    output logic        dma_done_o,
    output logic        dma_err_o,
    output logic        fifo_rd_en_o,
    input  logic [31:0] fifo_rd_out_i,
    input  logic        fifo_empty_i,
    output logic [31:0] axi_waddr_o,
    output logic [63:0] axi_wdata_o,
    output logic [7:0]  axi_wsel_o,
    output logic        axi_wvalid_o,
    output logic [3:0]  axi_wlen_o,
    output logic        axi_wfixed_o,
    input  logic        axi_werr_i,
    input  logic        axi_wrdy_i
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP_LO,
        S_CAP_LO,
        S_POP_HI,
        S_CAP_HI,
        S_WRITE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam bit          TMO_EN   = (WR_TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = 32'(WR_TIMEOUT) - 32'd1;

    state_t      r_state;
    logic [31:0] r_base;
    logic [31:0] r_ofs;
    logic [26:0] r_words;
    logic [31:0] r_tmo;
    logic [63:0] r_wdata;
    logic [7:0]  r_wsel;

    logic [31:0] r_axi_waddr;
    logic [63:0] r_axi_wdata;
    logic [7:0]  r_axi_wsel;
    logic        r_axi_wvalid;
    logic [3:0]  r_axi_wlen;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [26:0] w_words_in;
    logic [26:0] w_words_dec;
    logic        w_pop_state;
    logic        w_unused_bits;

    assign w_words_in    = dma_bit_len_i[31:5];
    assign w_words_dec   = r_words - 27'd1;
    assign w_pop_state   = (r_state == S_POP_LO) || (r_state == S_POP_HI);
    assign w_unused_bits = &{1'b0, dma_bit_len_i[4:0], dma_base_addr_i[2:0]};

    // The pop strobe is combinational so the FIFO advances on the edge that
    // leaves POP_*, and the popped word is present during the CAP_* cycle.
    // Gating with the flag itself guarantees no pop while empty.
    assign fifo_rd_en_o = w_pop_state && !fifo_empty_i && dma_enable_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_ofs        <= '0;
            r_words      <= '0;
            r_tmo        <= '0;
            r_wdata      <= '0;
            r_wsel       <= '0;
            r_axi_waddr  <= '0;
            r_axi_wdata  <= '0;
            r_axi_wsel   <= '0;
            r_axi_wvalid <= 1'b0;
            r_axi_wlen   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!dma_enable_i && (r_state != S_IDLE)) begin
                // Abort: any captured but unwritten data is simply dropped.
                r_state      <= S_IDLE;
                r_axi_waddr  <= '0;
                r_axi_wdata  <= '0;
                r_axi_wsel   <= '0;
                r_axi_wvalid <= 1'b0;
                r_axi_wlen   <= '0;
                r_busy       <= 1'b0;
                r_err        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (dma_enable_i && dma_start_i) begin
                            r_base  <= {dma_base_addr_i[31:3], 3'b000};
                            r_words <= w_words_in;
                            r_ofs   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= (w_words_in == '0) ? S_DONE : S_POP_LO;
                        end
                    end
                    S_POP_LO: begin
                        if (!fifo_empty_i) begin
                            r_state <= S_CAP_LO;
                        end
                    end
                    S_CAP_LO: begin
                        r_wdata[31:0] <= fifo_rd_out_i;
                        r_words       <= w_words_dec;
                        if (w_words_dec == '0) begin
                            r_wdata[63:32] <= '0;
                            r_wsel         <= 8'h0F;
                            r_state        <= S_WRITE;
                        end else begin
                            r_state <= S_POP_HI;
                        end
                    end
                    S_POP_HI: begin
                        if (!fifo_empty_i) begin
                            r_state <= S_CAP_HI;
                        end
                    end
                    S_CAP_HI: begin
                        r_wdata[63:32] <= fifo_rd_out_i;
                        r_words        <= w_words_dec;
                        r_wsel         <= 8'hFF;
                        r_state        <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_axi_waddr  <= r_base + r_ofs;
                        r_axi_wdata  <= r_wdata;
                        r_axi_wsel   <= r_wsel;
                        r_axi_wlen   <= 4'h1;
                        r_axi_wvalid <= 1'b1;
                        r_tmo        <= '0;
                        r_state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (axi_werr_i) begin
                            r_axi_waddr  <= '0;
                            r_axi_wdata  <= '0;
                            r_axi_wsel   <= '0;
                            r_axi_wvalid <= 1'b0;
                            r_axi_wlen   <= '0;
                            r_busy       <= 1'b0;
                            r_err        <= 1'b1;
                            r_state      <= S_ERR;
                        end else if (axi_wrdy_i) begin
                            r_axi_waddr  <= '0;
                            r_axi_wdata  <= '0;
                            r_axi_wsel   <= '0;
                            r_axi_wvalid <= 1'b0;
                            r_axi_wlen   <= '0;
                            r_ofs        <= r_ofs + 32'd8;
                            r_state      <= (r_words != '0) ? S_POP_LO : S_DONE;
                        end else if (TMO_EN && (r_tmo == TMO_LAST)) begin
                            r_axi_waddr  <= '0;
                            r_axi_wdata  <= '0;
                            r_axi_wsel   <= '0;
                            r_axi_wvalid <= 1'b0;
                            r_axi_wlen   <= '0;
                            r_busy       <= 1'b0;
                            r_err        <= 1'b1;
                            r_state      <= S_ERR;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_ERR: begin
                        r_err <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dma_busy_o   = r_busy;
    assign dma_done_o   = r_done;
    assign dma_err_o    = r_err;
    assign axi_waddr_o  = r_axi_waddr;
    assign axi_wdata_o  = r_axi_wdata;
    assign axi_wsel_o   = r_axi_wsel;
    assign axi_wvalid_o = r_axi_wvalid;
    assign axi_wlen_o   = r_axi_wlen;
    assign axi_wfixed_o = 1'b0;

endmodule

// File: doc/dma_writeback_engine.md
Name: dma_writeback_engine

Overview:
- Write-direction counterpart of the DMA read engine.
- Pops 32-bit words from a result FIFO (e.g. SHA-256 digest or stream output) and packs them pairwise into 64-bit beats, lower word first.
- Writes the beats to system memory through the AXI master system write bus, one single-beat transfer at a time.
- Sits between the result FIFO read port and the AXI master write channel; driven by control registers for base address and bit length.

Parameters:
- WR_TIMEOUT, 1024: cycles to wait for axi_wrdy_i after axi_wvalid_o rises before declaring an error; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- dma_enable_i  in  1  engine enable; low forces return to IDLE from any state
- dma_base_addr_i  in  32  destination byte address; bits [2:0] ignored (forced 0)
- dma_bit_len_i  in  32  bits to write; bits [4:0] ignored (whole 32-bit words only)
- dma_start_i  in  1  start request, level-sampled in IDLE
- dma_busy_o  out  1  high while a job is active
- dma_done_o  out  1  one-cycle pulse on successful job completion
- dma_err_o  out  1  high in ERR state
- fifo_rd_en_o  out  1  FIFO pop strobe; data valid on the following cycle
- fifo_rd_out_i  in  32  FIFO read data
- fifo_empty_i  in  1  FIFO empty flag
- axi_waddr_o  out  32  write address
- axi_wdata_o  out  64  write data
- axi_wsel_o  out  8  byte enables
- axi_wvalid_o  out  1  write request valid
- axi_wlen_o  out  4  burst length code; always 4'h1 when valid (single transfer)
- axi_wfixed_o  out  1  fixed-address burst; always 0
- axi_werr_i  in  1  write error response
- axi_wrdy_i  in  1  write accepted

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; internal offset, word counter and timeout counter 0.
- Job capture: in IDLE, when dma_enable_i && dma_start_i:
  - latch base = {dma_base_addr_i[31:3],3'b0};
  - words = dma_bit_len_i[31:5];
  - ofs = 0;
  - busy goes high the next cycle.
  - If words == 0, go to DONE directly.
- States:
  - IDLE.
  - POP_LO: wait for !fifo_empty_i, assert fifo_rd_en_o for exactly 1 cycle, go to CAP_LO.
  - CAP_LO: latch fifo_rd_out_i into wdata[31:0]; words--. If words after decrement == 0, set wdata[63:32]=0, wsel=8'h0F and go to WRITE; else go to POP_HI.
  - POP_HI: as POP_LO, then go to CAP_HI.
  - CAP_HI: latch fifo_rd_out_i into wdata[63:32]; words--; wsel=8'hFF; go to WRITE.
  - WRITE: drive axi_waddr_o=base+ofs, axi_wdata_o, axi_wsel_o, axi_wlen_o=4'h1, axi_wvalid_o=1; clear timeout counter; go to WAIT.
  - WAIT: hold all axi_w* stable. Exits:
    - axi_werr_i → ERR (error has priority over wrdy in the same cycle).
    - axi_wrdy_i && !axi_werr_i → deassert valid, zero addr/data/sel/len, ofs += 8; go to POP_LO if words != 0, else DONE.
    - Timeout counter reaches WR_TIMEOUT (non-zero) → ERR.
  - DONE: dma_done_o=1 for one cycle, busy=0, return to IDLE. A new job needs dma_start_i still or again high in IDLE (level semantics as in the read engine; software clears start).
  - ERR: all axi_w* 0, dma_err_o=1, busy=0; stays until dma_enable_i low, then IDLE.
- Enable drop: dma_enable_i low in any non-IDLE state → next cycle IDLE, all axi_w* and fifo_rd_en_o 0, busy 0, no done pulse. Any popped but unwritten word is discarded.
- FIFO rules:
  - fifo_rd_en_o is never asserted while fifo_empty_i is high.
  - Never more than one pop per two cycles.
  - Total pops per job = words exactly.
- Arithmetic:
  - ofs is 32-bit and wraps modulo 2^32; address = base + ofs, wrapping.
  - Word counter is 27 bits.
- Throughput: with non-empty FIFO and wrdy in the first WAIT cycle, 6 cycles per 64-bit beat.

Test Plan:
- base=0x1000_0000, len=256 bits, FIFO preloaded 0x11..0x88, wrdy after 1 cycle → 4 writes to 0x1000_0000/08/10/18 with data {0x22,0x11}, ..., sel=FF each; 8 pops; done pulse once; busy low after.
- len=96 bits, 3 words A,B,C → write 1 {B,A} sel=FF at base; write 2 {0,C} sel=0F at base+8; done.
- len=0 or len=31 → no pops, no writes, done pulse 2 cycles after start.
- FIFO empty for 20 cycles mid-job → no fifo_rd_en_o while empty; job resumes and completes with correct data.
- axi_werr_i with axi_wrdy_i on second beat → ERR, dma_err_o=1, valid dropped, no further pops; dma_enable_i low → IDLE, err cleared.
- WR_TIMEOUT=16, wrdy never asserted → ERR after 16 WAIT cycles; async rst_i asserted mid-WAIT → all outputs 0 immediately, before the next clock edge.
